char_normalizer: RTL

CHAR_NORMALIZER -- requirements
Module: char_normalizer

---
 rtl/char_normalizer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/char_normalizer.sv
// ============================================================================
// char_normalizer
// ----------------------------------------------------------------------------
// Character stream normalizer sitting in front of the block checker.
//
// Every accepted character is classified as whitespace (0x20, 0x09, 0x0A,
// 0x0D) or text. A two-state FSM remembers the class of the last accepted
// character so that each run of whitespace collapses to one 0x20. Surplus
// whitespace is accepted but discarded and counted in ws_drop_cnt. Written
// characters go through a DEPTH-entry FIFO with a valid/ready handshake on
// both sides.
//
// Optional feature (compile-time macro CHAR_NORMALIZER_CASE_FOLD_EN):
//   defined   -> 'A'..'Z' are stored as 'a'..'z'
//   undefined -> text is stored unchanged
//
// Parameters
//   DEPTH        FIFO entry count, power of two, >= 2 (default 8)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   in_valid     upstream character present on in_char
//   in_char[7:0] upstream ASCII character
//   in_ready     block accepts a character this cycle (registered state only)
//   out_valid    out_char holds a normalized character (FIFO non-empty)
//   out_char[7:0] FIFO head entry
//   out_ready    downstream consumes out_char this cycle
//   ws_drop_cnt[7:0] discarded whitespace count since reset, saturates at 255
// ============================================================================
module char_normalizer #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_char,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_char,
    input  logic       out_ready,
    output logic [7:0] ws_drop_cnt
);

    localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {
        S_TEXT  = 1'b0,
        S_SPACE = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------------
    function automatic logic is_ws(input logic [7:0] c);
        return (c == 8'h20) || (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D);
    endfunction

    function automatic logic [7:0] fold_char(input logic [7:0] c);
`ifdef CHAR_NORMALIZER_CASE_FOLD_EN
        if ((c >= 8'h41) && (c <= 8'h5A)) begin
            return c + 8'h20;
        end
        return c;
`else
        return c;
`endif
    endfunction

    // Saturating 8-bit increment for the drop counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'h01);
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t            state_q;
    state_t            state_d;
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;
    logic [7:0]        drop_q;
    // Cleared by reset, set on the first edge afterwards; holds in_ready low
    // while reset is asserted without routing reset into the ready path.
    logic              live_q;
    logic [7:0]        mem [DEPTH];

    logic              accept;
    logic              char_ws;
    logic              push;
    logic              drop;
    logic              pop;
    logic [7:0]        wdata;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    assign in_ready  = live_q && (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign out_char  = mem[head_q];

    assign accept  = in_valid && in_ready;
    assign char_ws = is_ws(in_char);
    assign pop     = out_valid && out_ready;
    assign wdata   = char_ws ? 8'h20 : fold_char(in_char);

    // ------------------------------------------------------------------------
    // FSM: next state and write/drop decision
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        drop    = 1'b0;
        if (accept) begin
            if (!char_ws) begin
                push    = 1'b1;
                state_d = S_TEXT;
            end else if (state_q == S_TEXT) begin
                push    = 1'b1;
                state_d = S_SPACE;
            end else begin
                // Repeated whitespace: handshake completes, nothing stored.
                drop    = 1'b1;
                state_d = S_SPACE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_TEXT;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO control: pointers, occupancy, drop counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live_q  <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            live_q <= 1'b1;
            // DEPTH is a power of two, so natural pointer overflow wraps.
            if (push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (drop) begin
                drop_q <= sat_inc8(drop_q);
            end
        end
    end

    assign ws_drop_cnt = drop_q;

    // ------------------------------------------------------------------------
    // FIFO storage (not reset; out_char is don't-care while empty)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_q] <= wdata;
        end
    end

endmodule
